axi_ar_arbiter: RTL and testbench

//  Read-path arbiter: shares one AR/R slave-side path between masters M0 and M1.
//  - Grants one master at a time, round-robin.
//  - Forwards the granted AR request to the address decoder stage.
//  - Steers the R burst back to its owner.
//  - Holds the grant until RLAST handshakes: one outstanding read at a time.

---
 rtl/axi_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 19 +
 rtl/axi_ar_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_ar_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI read-address arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Slave-side ID carries the owning master index above the master ID.
  localparam int IDS_BITS = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins; on a tie the prio index wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = prio;
    if (req == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (req == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/axi_ar_arbiter.sv
// Shares one AR/R slave path between two masters; the grant is held from AR
// acceptance until the RLAST beat handshakes, so only one read is ever in flight.
module axi_ar_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic RR_INIT   = 1'b0,
  parameter int   ID_BITS   = 4,
  parameter int   ADDR_BITS = 32,
  parameter int   LEN_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_BITS-1:0]   ARID_M0,
  input  logic [ADDR_BITS-1:0] ARADDR_M0,
  input  logic [LEN_BITS-1:0]  ARLEN_M0,
  input  logic [2:0]           ARSIZE_M0,
  input  logic [1:0]           ARBURST_M0,
  input  logic                 ARVALID_M0,
  output logic                 ARREADY_M0,
  input  logic [ID_BITS-1:0]   ARID_M1,
  input  logic [ADDR_BITS-1:0] ARADDR_M1,
  input  logic [LEN_BITS-1:0]  ARLEN_M1,
  input  logic [2:0]           ARSIZE_M1,
  input  logic [1:0]           ARBURST_M1,
  input  logic                 ARVALID_M1,
  output logic                 ARREADY_M1,
  output logic [IDS_BITS-1:0]  ARID_S,
  output logic [ADDR_BITS-1:0] ARADDR_S,
  output logic [LEN_BITS-1:0]  ARLEN_S,
  output logic [2:0]           ARSIZE_S,
  output logic [1:0]           ARBURST_S,
  output logic                 ARVALID_S,
  input  logic                 ARREADY_S,
  input  logic [IDS_BITS-1:0]  RID_S,
  input  logic                 RLAST_S,
  input  logic                 RVALID_S,
  output logic                 RREADY_S,
  output logic [ID_BITS-1:0]   RID_M0,
  output logic                 RVALID_M0,
  input  logic                 RREADY_M0,
  output logic [ID_BITS-1:0]   RID_M1,
  output logic                 RVALID_M1,
  input  logic                 RREADY_M1,
  output logic                 len_err,
  output arb_state_t           fsm_state
);

  // Handshake rule on every channel: a transfer happens in a cycle where both
  // VALID and READY are high; VALID never waits on READY.

  arb_state_t                      state, state_next;
  logic                            owner;
  logic                            prio;
  logic [LEN_BITS-1:0]             beat_cnt;
  logic [LEN_BITS-1:0]             exp_len;
  logic                            len_err_next;

  logic                            gnt_idx;
  logic                            gnt_valid;
  logic [IDS_BITS-ID_BITS-1:0]     owner_ext;
  logic [ID_BITS-1:0]              arid_sel;
  logic                            arvalid_sel;
  logic                            rready_sel;
  logic                            ar_hs;
  logic                            r_hs;

  rr_arb2 u_rr_arb2 (
    .req       ({ARVALID_M1, ARVALID_M0}),
    .prio      (prio),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign owner_ext   = {{(IDS_BITS-ID_BITS-1){1'b0}}, owner};
  assign arid_sel    = (owner == M1) ? ARID_M1    : ARID_M0;
  assign arvalid_sel = (owner == M1) ? ARVALID_M1 : ARVALID_M0;
  assign rready_sel  = (owner == M1) ? RREADY_M1  : RREADY_M0;

  assign ar_hs = (state == ADDR) && arvalid_sel && ARREADY_S;
  assign r_hs  = (state == DATA) && RVALID_S && rready_sel;

  assign fsm_state = state;

  // Field muxes follow the registered owner only, never the live request lines.
  assign ARID_S    = {owner_ext, arid_sel};
  assign ARADDR_S  = (owner == M1) ? ARADDR_M1  : ARADDR_M0;
  assign ARLEN_S   = (owner == M1) ? ARLEN_M1   : ARLEN_M0;
  assign ARSIZE_S  = (owner == M1) ? ARSIZE_M1  : ARSIZE_M0;
  assign ARBURST_S = (owner == M1) ? ARBURST_M1 : ARBURST_M0;
  assign RID_M0    = RID_S[ID_BITS-1:0];
  assign RID_M1    = RID_S[ID_BITS-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (gnt_valid) state_next = ADDR;
      ADDR:    if (ar_hs) state_next = DATA;
      DATA:    if (r_hs && RLAST_S) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RREADY_S   = 1'b0;
    RVALID_M0  = 1'b0;
    RVALID_M1  = 1'b0;
    case (state)
      ADDR: begin
        ARVALID_S  = arvalid_sel;
        ARREADY_M0 = (owner == M0) && ARREADY_S;
        ARREADY_M1 = (owner == M1) && ARREADY_S;
      end
      DATA: begin
        RREADY_S  = rready_sel;
        RVALID_M0 = (owner == M0) && RVALID_S;
        RVALID_M1 = (owner == M1) && RVALID_S;
      end
      default: ;
    endcase
  end

  // The last beat must land exactly on the latched ARLEN; a foreign RID is
  // flagged on any beat but the beat is still delivered to the owner.
  assign len_err_next = r_hs && ((RLAST_S && (beat_cnt != exp_len)) ||
                                 (RID_S[IDS_BITS-1:ID_BITS] != owner_ext));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= M0;
      prio     <= RR_INIT;
      beat_cnt <= '0;
      exp_len  <= '0;
      len_err  <= 1'b0;
    end else begin
      state   <= state_next;
      len_err <= len_err_next;
      case (state)
        IDLE: if (gnt_valid) owner <= gnt_idx;
        ADDR: begin
          if (ar_hs) begin
            exp_len  <= ARLEN_S;
            beat_cnt <= '0;
            prio     <= ~owner;
          end
        end
        DATA: if (r_hs) beat_cnt <= beat_cnt + LEN_BITS'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Randomized bench for axi_ar_arbiter with a round-robin / burst-length reference model.
module tb_axi_ar_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][3:0]  arid;
  logic [1:0][31:0] araddr;
  logic [1:0][3:0]  arlen;
  logic [1:0][2:0]  arsize;
  logic [1:0][1:0]  arburst;
  logic [1:0]       arvalid;
  logic [1:0]       arready_m;
  logic [7:0]       arid_s;
  logic [31:0]      araddr_s;
  logic [3:0]       arlen_s;
  logic [2:0]       arsize_s;
  logic [1:0]       arburst_s;
  logic             arvalid_s;
  logic             arready_s;
  logic [7:0]       rid_s;
  logic             rlast_s;
  logic             rvalid_s;
  logic             rready_s;
  logic [1:0][3:0]  rid_m;
  logic [1:0]       rvalid_m;
  logic [1:0]       rready_m;
  logic             len_err;
  arb_state_t       fsm_state;

  axi_ar_arbiter dut (
    .clk(clk), .rst(rst),
    .ARID_M0(arid[0]), .ARADDR_M0(araddr[0]), .ARLEN_M0(arlen[0]),
    .ARSIZE_M0(arsize[0]), .ARBURST_M0(arburst[0]),
    .ARVALID_M0(arvalid[0]), .ARREADY_M0(arready_m[0]),
    .ARID_M1(arid[1]), .ARADDR_M1(araddr[1]), .ARLEN_M1(arlen[1]),
    .ARSIZE_M1(arsize[1]), .ARBURST_M1(arburst[1]),
    .ARVALID_M1(arvalid[1]), .ARREADY_M1(arready_m[1]),
    .ARID_S(arid_s), .ARADDR_S(araddr_s), .ARLEN_S(arlen_s),
    .ARSIZE_S(arsize_s), .ARBURST_S(arburst_s),
    .ARVALID_S(arvalid_s), .ARREADY_S(arready_s),
    .RID_S(rid_s), .RLAST_S(rlast_s), .RVALID_S(rvalid_s), .RREADY_S(rready_s),
    .RID_M0(rid_m[0]), .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]),
    .RID_M1(rid_m[1]), .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]),
    .len_err(len_err), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds priority, and the ARLEN of the accepted request.
  bit         m_prio = 1'b0;
  logic [3:0] m_len;
  logic [7:0] exp_q[$];

  function automatic bit model_winner(input bit [1:0] req);
    if (req == 2'b11) return m_prio;
    return req[1];
  endfunction

  task automatic rand_fields();
    for (int m = 0; m < 2; m++) begin
      arid[m]    = 4'($urandom);
      araddr[m]  = $urandom;
      arlen[m]   = 4'($urandom_range(0, 5));
      arsize[m]  = 3'($urandom);
      arburst[m] = 2'($urandom);
    end
  endtask

  task automatic ar_phase(input bit [1:0] req, input int stall, output bit win);
    logic [7:0] exp_id;
    win = model_winner(req);
    exp_q.push_back({3'b000, win, arid[win]});
    @(posedge clk); #1;
    arvalid   = req;
    arready_s = 1'b0;
    @(negedge clk);
    n_checks++;
    if (arvalid_s !== 1'b0) $display("FAIL ar_latency: ARVALID_S=%b want 0", arvalid_s);
    else n_pass++;
    @(posedge clk); #1;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      n_checks++;
      if (arvalid_s !== 1'b1 || araddr_s !== araddr[win] || arready_m !== 2'b00)
        $display("FAIL ar_stall: valid=%b addr=%h ready=%b want 1 %h 00",
                 arvalid_s, araddr_s, arready_m, araddr[win]);
      else n_pass++;
      @(posedge clk); #1;
    end
    arready_s = 1'b1;
    @(negedge clk);
    exp_id = exp_q.pop_front();
    n_checks++;
    if (arid_s !== exp_id || arvalid_s !== 1'b1 || araddr_s !== araddr[win] ||
        arlen_s !== arlen[win] || arsize_s !== arsize[win] || arburst_s !== arburst[win])
      $display("FAIL ar_fields: id=%h v=%b addr=%h len=%h size=%h burst=%h want id=%h v=1 addr=%h len=%h size=%h burst=%h",
               arid_s, arvalid_s, araddr_s, arlen_s, arsize_s, arburst_s,
               exp_id, araddr[win], arlen[win], arsize[win], arburst[win]);
    else n_pass++;
    n_checks++;
    if (arready_m !== (2'b01 << win))
      $display("FAIL ar_ready_steer: ARREADY_M=%b want %b", arready_m, 2'b01 << win);
    else n_pass++;
    m_len = arlen[win];
    @(posedge clk); #1;
    arvalid   = 2'b00;
    arready_s = 1'b0;
    m_prio    = ~win;
  endtask

  task automatic r_phase(input bit own, input int nbeats, input logic [3:0] rid_hi,
                         input int stall);
    bit exp_err;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      rvalid_s       = 1'b1;
      rid_s          = {rid_hi, 4'($urandom)};
      rlast_s        = (i == nbeats - 1);
      rready_m[own]  = 1'b0;
      rready_m[~own] = 1'($urandom);
      if (i == 0) begin
        for (int c = 0; c < stall; c++) begin
          @(negedge clk);
          n_checks++;
          if (rready_s !== 1'b0 || rvalid_m !== (2'b01 << own))
            $display("FAIL r_stall: RREADY_S=%b RVALID_M=%b want 0 %b",
                     rready_s, rvalid_m, 2'b01 << own);
          else n_pass++;
          @(posedge clk); #1;
        end
      end
      rready_m[own] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rready_s !== 1'b1 || rvalid_m !== (2'b01 << own) || rid_m[own] !== rid_s[3:0])
        $display("FAIL r_route: RREADY_S=%b RVALID_M=%b RID=%h want 1 %b %h",
                 rready_s, rvalid_m, rid_m[own], 2'b01 << own, rid_s[3:0]);
      else n_pass++;
      exp_err = (rid_hi != {3'b000, own}) || ((i == nbeats - 1) && ((i % 16) != int'(m_len)));
      @(posedge clk); #1;
      rvalid_s = 1'b0;
      rlast_s  = 1'b0;
      rready_m = 2'b00;
      @(negedge clk);
      n_checks++;
      if (len_err !== exp_err)
        $display("FAIL len_err beat %0d: got %b want %b", i, len_err, exp_err);
      else n_pass++;
    end
    n_checks++;
    if (fsm_state !== IDLE) $display("FAIL r_done_idle: state=%0d want %0d", fsm_state, IDLE);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (len_err !== 1'b0) $display("FAIL len_err_pulse: got %b want 0", len_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    bit w;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fsm_state !== IDLE || arvalid_s !== 1'b0 || arready_m !== 2'b00 ||
        rvalid_m !== 2'b00 || rready_s !== 1'b0 || len_err !== 1'b0)
      $display("FAIL reset_state: st=%0d arv=%b arr=%b rv=%b rr=%b err=%b want all 0",
               fsm_state, arvalid_s, arready_m, rvalid_m, rready_s, len_err);
    else n_pass++;
    rst = 1'b0;
    // Put M0 in flight (leaves prio on M1), then reset mid-burst.
    rand_fields();
    ar_phase(2'b01, 0, w);
    @(posedge clk); #1;
    rvalid_s = 1'b1;
    rready_m = 2'b11;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (fsm_state !== IDLE || rvalid_m !== 2'b00 || rready_s !== 1'b0 || arvalid_s !== 1'b0)
      $display("FAIL reset_async: st=%0d rv=%b rr=%b arv=%b want IDLE 00 0 0",
               fsm_state, rvalid_m, rready_s, arvalid_s);
    else n_pass++;
    rvalid_s = 1'b0;
    rready_m = 2'b00;
    @(negedge clk);
    rst    = 1'b0;
    m_prio = 1'b0;
    // Tie right after reset must go to the RR_INIT master.
    rand_fields();
    ar_phase(2'b11, 0, w);
    r_phase(w, int'(m_len) + 1, {3'b000, w}, 0);
  endtask

  task automatic test_single_m1();
    bit w;
    rand_fields();
    araddr[1] = 32'h0001_0040;
    arlen[1]  = 4'd3;
    ar_phase(2'b10, 0, w);
    r_phase(w, 4, {3'b000, w}, 0);
  endtask

  task automatic test_alternate();
    bit w;
    for (int k = 0; k < 4; k++) begin
      rand_fields();
      ar_phase(2'b11, 0, w);
      r_phase(w, int'(m_len) + 1, {3'b000, w}, 0);
    end
  endtask

  task automatic test_backpressure();
    bit w;
    rand_fields();
    ar_phase(2'b01, 5, w);
    r_phase(w, int'(m_len) + 1, {3'b000, w}, 3);
  endtask

  task automatic test_short_burst();
    bit w;
    rand_fields();
    arlen[0] = 4'd3;
    ar_phase(2'b01, 0, w);
    r_phase(w, 3, {3'b000, w}, 0);
  endtask

  task automatic test_bad_id();
    bit w;
    rand_fields();
    ar_phase(2'b01, 0, w);
    r_phase(w, int'(m_len) + 1, 4'h1, 0);
  endtask

  task automatic test_random();
    bit w;
    int nb;
    for (int k = 0; k < 12; k++) begin
      rand_fields();
      ar_phase(2'($urandom_range(1, 3)), $urandom_range(0, 2), w);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : int'(m_len) + 1;
      r_phase(w, nb, ($urandom_range(0, 4) == 0) ? 4'($urandom) : {3'b000, w},
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = '0;
    arready_s = 1'b0; rid_s = '0; rlast_s = 1'b0; rvalid_s = 1'b0; rready_m = '0;
    test_reset();
    test_single_m1();
    test_alternate();
    test_backpressure();
    test_short_burst();
    test_bad_id();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
